// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and rotation helper for the 8-way round-robin arbiter.
// Pure declarations; no timing or flow-control behaviour of its own.
package arb_pkg;

   localparam int N_REQ        = 8;
   localparam int IDX_W        = 3;
   localparam int HOLD_W       = 8;
   localparam int MAX_HOLD_DEF = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Rotate right by s so that bit s of v lands on bit 0; the priority search then
   // starts at the round-robin pointer and wraps 7->0 for free.
   function automatic logic [N_REQ-1:0] rot_dn(input logic [N_REQ-1:0] v,
                                                input logic [IDX_W-1:0] s);
      logic [N_REQ-1:0] r;
      logic [IDX_W-1:0] k;
      r = '0;
      for (int i = 0; i < N_REQ; i++) begin
         k    = IDX_W'(i) + s;
         r[i] = v[k];
      end
      return r;
   endfunction

endpackage

// File: rtl/prio_enc_8.sv
// Lowest-index-first priority encoder: 8 request bits in, winning index plus any-valid out.
// Purely combinational, zero latency, no backpressure.
module prio_enc_8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   output logic [IDX_W-1:0] idx,
   output logic             vld
);

   always_comb begin
      idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

   assign vld = |req;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter, 8 requesters, one owner at a time with done/drop/MAX_HOLD release.
// Grant registered one cycle after req; non-owner req changes ignored while an owner holds.
module rr_arbiter_8 #(
   parameter int N_REQ    = arb_pkg::N_REQ,
   parameter int MAX_HOLD = arb_pkg::MAX_HOLD_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic                      done,
   output logic [N_REQ-1:0]          gnt,
   output logic [arb_pkg::IDX_W-1:0] gnt_idx,
   output logic                      gnt_valid,
   output logic                      timeout
);

   import arb_pkg::*;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [N_REQ-1:0]  ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  ptr, ptr_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic [N_REQ-1:0]  gnt_nxt;
   logic [IDX_W-1:0]  idx_nxt;
   logic              vld_nxt;
   logic              to_nxt;

   logic [N_REQ-1:0]  req_rot;
   logic [IDX_W-1:0]  enc_idx;
   logic              enc_vld;
   logic [IDX_W-1:0]  win_idx;
   logic              owner_req;
   logic              at_limit;

   assign req_rot = rot_dn(req, ptr);

   prio_enc_8 u_prio_enc (
      .req (req_rot),
      .idx (enc_idx),
      .vld (enc_vld)
   );

   // Undo the rotation: the 3-bit add wraps mod 8 naturally.
   assign win_idx   = enc_idx + ptr;
   assign owner_req = req[gnt_idx];
   assign at_limit  = (hold_cnt == HOLD_LAST);

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      hold_nxt  = hold_cnt;
      gnt_nxt   = gnt;
      idx_nxt   = gnt_idx;
      vld_nxt   = gnt_valid;
      to_nxt    = 1'b0;
      case (state)
         IDLE: begin
            hold_nxt = '0;
            if (enc_vld) begin
               state_nxt = BUSY;
               gnt_nxt   = ONE_HOT0 << win_idx;
               idx_nxt   = win_idx;
               vld_nxt   = 1'b1;
            end
         end
         BUSY: begin
            if (!at_limit) begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
            if (done || !owner_req || at_limit) begin
               state_nxt = IDLE;
               gnt_nxt   = '0;
               idx_nxt   = '0;
               vld_nxt   = 1'b0;
               hold_nxt  = '0;
               ptr_nxt   = gnt_idx + IDX_W'(1);
               // A voluntary release on the limit cycle wins over the forced one.
               to_nxt    = at_limit && !done && owner_req;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         hold_cnt  <= hold_nxt;
         gnt       <= gnt_nxt;
         gnt_idx   <= idx_nxt;
         gnt_valid <= vld_nxt;
         timeout   <= to_nxt;
      end
   end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: vector table plus hand-written hold-limit sequences.
module tb_rr_arbiter_8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic       done = 1'b0;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rr_arbiter_8 #(
      .N_REQ    (8),
      .MAX_HOLD (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic       done;
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       vld;
      logic       to;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic [7:0] q, input logic d,
                               input logic [7:0] g, input logic [2:0] x,
                               input logic v, input logic t);
      vec_t s;
      s.rst = r; s.req = q; s.done = d;
      s.gnt = g; s.idx = x; s.vld = v; s.to = t;
      return s;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                           input logic ev, input logic et);
      chk({tag, " gnt"}, gnt, eg);
      chk({tag, " gnt_idx"}, 8'(gnt_idx), 8'(ei));
      chk({tag, " gnt_valid"}, 8'(gnt_valid), 8'(ev));
      chk({tag, " timeout"}, 8'(timeout), 8'(et));
      chk({tag, " onehot0"}, 8'($onehot0(gnt)), 8'd1);
   endtask

   task automatic step(input logic r, input logic [7:0] q, input logic d);
      @(negedge clk);
      rst  = r;
      req  = q;
      done = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] oh;

      // reset, single requester, done after three cycles, regrant to 0
      tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0));
      tbl.push_back(mk(1, 8'h01, 0, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'h01, 0, 8'h01, 0, 1, 0));
      tbl.push_back(mk(0, 8'h01, 0, 8'h01, 0, 1, 0));
      tbl.push_back(mk(0, 8'h01, 0, 8'h01, 0, 1, 0));
      tbl.push_back(mk(0, 8'h01, 1, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'h01, 0, 8'h01, 0, 1, 0));
      tbl.push_back(mk(0, 8'h01, 1, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 0, 0));
      // all requesting: grants rotate 0..7,0 with one idle cycle between
      tbl.push_back(mk(1, 8'hFF, 0, 8'h00, 0, 0, 0));
      for (int k = 0; k < 9; k++) begin
         oh = 8'h01 << (k % 8);
         tbl.push_back(mk(0, 8'hFF, 0, oh, 3'(k % 8), 1, 0));
         tbl.push_back(mk(0, 8'hFF, 1, 8'h00, 0, 0, 0));
      end
      // owner 3 drops its request, search restarts from 4
      tbl.push_back(mk(0, 8'h08, 0, 8'h08, 3, 1, 0));
      tbl.push_back(mk(0, 8'h24, 0, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'h24, 0, 8'h20, 5, 1, 0));
      tbl.push_back(mk(0, 8'h25, 0, 8'h20, 5, 1, 0));
      // reset mid-busy, then owner 6, reset again, 8'h41 goes to 0 then 6
      tbl.push_back(mk(1, 8'hFF, 0, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'h40, 0, 8'h40, 6, 1, 0));
      tbl.push_back(mk(0, 8'h40, 0, 8'h40, 6, 1, 0));
      tbl.push_back(mk(1, 8'h40, 0, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'h41, 0, 8'h01, 0, 1, 0));
      tbl.push_back(mk(0, 8'h41, 1, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'h41, 0, 8'h40, 6, 1, 0));
      tbl.push_back(mk(0, 8'h41, 1, 8'h00, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].req, tbl[i].done);
         chk_outs($sformatf("v%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].vld, tbl[i].to);
      end

      // forced release: owner 7 holds exactly 16 cycles, then timeout with gnt=0
      step(1, 8'h00, 0);
      chk_outs("to_rst", 8'h00, 0, 0, 0);
      for (int c = 0; c < 16; c++) begin
         step(0, 8'h80, 0);
         chk_outs($sformatf("hold7_c%0d", c), 8'h80, 7, 1, 0);
      end
      step(0, 8'h81, 0);
      chk_outs("forced_rel", 8'h00, 0, 0, 1);
      // ptr wrapped to 0: requester 0 wins over 7
      step(0, 8'h81, 0);
      chk_outs("after_to", 8'h01, 0, 1, 0);

      // done on the limit cycle: normal release, no timeout
      for (int c = 1; c < 16; c++) begin
         step(0, 8'h81, 0);
         chk_outs($sformatf("hold0_c%0d", c), 8'h01, 0, 1, 0);
      end
      step(0, 8'h81, 1);
      chk_outs("done_at_lim", 8'h00, 0, 0, 0);
      step(0, 8'h00, 0);
      chk_outs("post_done_lim", 8'h00, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
